// File: rtl/slow_tick_timer.sv
// Countdown interval timer clocked by clk_in. It treats the divided slow clock as
// asynchronous data and counts its synchronised rising edges.
module slow_tick_timer #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tick,
  output logic             expired
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic [ARM_W-1:0]       arm_cnt_r;
  logic                   armed_s;
  logic                   tick_s;
  logic                   load_zero_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       count_nxt_s;
  logic                   expired_r;
  logic                   expired_nxt_s;
  logic                   busy_r;
  logic                   paused_r;

  // Synchroniser chain plus one-cycle-delayed copy of its last stage
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], slow_clk};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Arm counter masks edges the chain fills with straight after reset release
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      arm_cnt_r <= '0;
    end else if (arm_cnt_r != ARM_DONE) begin
      arm_cnt_r <= arm_cnt_r + ARM_W'(1);
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

  assign armed_s     = (arm_cnt_r == ARM_DONE);
  assign tick_s      = sync_r[SYNC_STAGES-1] & ~prev_r & armed_s;
  assign load_zero_s = (load_val == '0);

  // Next state and next count: abort > pause > start > tick
  always_comb begin
    state_nxt_s   = state_r;
    count_nxt_s   = count_r;
    expired_nxt_s = 1'b0;
    if (abort) begin
      state_nxt_s = ST_IDLE;
      count_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !load_zero_s) begin
            state_nxt_s = ST_RUN;
            count_nxt_s = load_val;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_nxt_s = ST_PAUSE;
          end else if (start) begin
            if (load_zero_s) begin
              state_nxt_s = ST_IDLE;
              count_nxt_s = '0;
            end else begin
              count_nxt_s = load_val;
            end
          end else if (tick_s) begin
            if (count_r > CNT_W'(1)) begin
              count_nxt_s = count_r - CNT_W'(1);
            end else begin
              expired_nxt_s = 1'b1;
              if (auto_reload && !load_zero_s) begin
                count_nxt_s = load_val;
              end else begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = '0;
              end
            end
          end else begin
            count_nxt_s = count_r;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = '0;
        end
      endcase
    end
  end

  // State, count and registered flag decodes
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      expired_r <= 1'b0;
      busy_r    <= 1'b0;
      paused_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      expired_r <= expired_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      paused_r  <= (state_nxt_s == ST_PAUSE);
    end
  end

  assign count   = count_r;
  assign busy    = busy_r;
  assign paused  = paused_r;
  assign tick    = tick_s;
  assign expired = expired_r;

endmodule
